// File: rtl/lc3_pipe_pkg.sv
// Shared types for the LC-3 pipeline advance/stall/flush sequencer.
package lc3_pipe_pkg;

  localparam int unsigned WORD_W = 16;

  // Value written into a stage register when it is flushed.
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_HELD = 2'd1,  // imem returned, waiting on dmem
    D_HELD = 2'd2   // dmem returned, waiting on imem
  } stall_state_t;

  // Stage load enables and bubble strobes, bundled for the output decode.
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } stage_ctl_t;

endpackage

// File: rtl/perf_ctr.sv
// Free-running event counter that wraps modulo 2^CNT_W.
module perf_ctr #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one per cycle with inc high; synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Advance/stall/flush sequencer for the 5-stage LC-3 pipeline. Holds an early
// cache return until the other cache completes so both sides advance together.
module pipe_stall_ctrl
  import lc3_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_resp,
  input  logic [WORD_W-1:0]  imem_rdata,
  output logic               imem_read,
  output logic [WORD_W-1:0]  if_instr,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic               dmem_resp,
  input  logic [WORD_W-1:0]  dmem_rdata,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [WORD_W-1:0]  mem_rdata,
  input  logic               load_use,
  input  logic               br_taken,
  output logic               load_pc,
  output logic               load_if_id,
  output logic               load_id_ex,
  output logic               load_ex_mem,
  output logic               load_mem_wb,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               flush_ex_mem,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  stall_state_t      state_q;
  stall_state_t      state_d;
  logic [WORD_W-1:0] ihold_q;
  logic [WORD_W-1:0] dhold_q;
  logic              i_ok;
  logic              d_ok;
  logic              adv;
  logic              adv_run;
  logic              ihold_en;
  logic              dhold_en;
  logic              stall_inc;
  logic              flush_inc;
  stage_ctl_t        ctl;

  // Completion qualifiers and the combined advance condition.
  always_comb begin
    i_ok      = imem_resp | (state_q == I_HELD);
    d_ok      = ~mem_req | dmem_resp | (state_q == D_HELD);
    adv       = i_ok & d_ok;
    adv_run   = adv & ~reset;
    ihold_en  = (state_q == RUN) & imem_resp & ~d_ok;
    dhold_en  = (state_q == RUN) & mem_req & dmem_resp & ~imem_resp;
    stall_inc = ~reset & ~adv;
    flush_inc = adv_run & br_taken;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: park in a HELD state when exactly one cache has returned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (ihold_en) begin
          state_d = I_HELD;
        end else if (dhold_en) begin
          state_d = D_HELD;
        end
      end
      I_HELD: begin
        if (d_ok) begin
          state_d = RUN;
        end
      end
      D_HELD: begin
        if (imem_resp) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Capture the early return so it is consumed exactly once on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ihold_q <= NOP_WORD;
      dhold_q <= NOP_WORD;
    end else begin
      if (ihold_en) begin
        ihold_q <= imem_rdata;
      end
      if (dhold_en) begin
        dhold_q <= dmem_rdata;
      end
    end
  end

  // Outputs: cache strobes, data muxes, and enables (branch beats load-use).
  always_comb begin
    ctl        = '0;
    imem_read  = ~reset & (state_q != I_HELD);
    dmem_read  = ~reset & mem_req & ~mem_we & (state_q != D_HELD);
    dmem_write = ~reset & mem_req & mem_we & (state_q != D_HELD);
    if_instr   = (state_q == I_HELD) ? ihold_q : imem_rdata;
    mem_rdata  = (state_q == D_HELD) ? dhold_q : dmem_rdata;
    if (adv_run) begin
      if (br_taken) begin
        ctl = '{load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1,
                load_ex_mem: 1'b1, load_mem_wb: 1'b1, flush_if_id: 1'b1,
                flush_id_ex: 1'b1, flush_ex_mem: 1'b1};
      end else if (load_use) begin
        ctl = '{load_pc: 1'b0, load_if_id: 1'b0, load_id_ex: 1'b1,
                load_ex_mem: 1'b1, load_mem_wb: 1'b1, flush_if_id: 1'b0,
                flush_id_ex: 1'b1, flush_ex_mem: 1'b0};
      end else begin
        ctl = '{load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1,
                load_ex_mem: 1'b1, load_mem_wb: 1'b1, flush_if_id: 1'b0,
                flush_id_ex: 1'b0, flush_ex_mem: 1'b0};
      end
    end
  end

  assign load_pc      = ctl.load_pc;
  assign load_if_id   = ctl.load_if_id;
  assign load_id_ex   = ctl.load_id_ex;
  assign load_ex_mem  = ctl.load_ex_mem;
  assign load_mem_wb  = ctl.load_mem_wb;
  assign flush_if_id  = ctl.flush_if_id;
  assign flush_id_ex  = ctl.flush_id_ex;
  assign flush_ex_mem = ctl.flush_ex_mem;

  perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl with a scoreboard queue.
module tb_pipe_stall_ctrl;

  localparam int unsigned CW = 4;

  // ctl layout: {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem, imem_rd, dmem_rd, dmem_wr}
  localparam logic [4:0] LD_NONE = 5'b00000;
  localparam logic [4:0] LD_ALL  = 5'b11111;
  localparam logic [4:0] LD_LU   = 5'b00111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_LU   = 3'b010;
  localparam logic [2:0] FL_BR   = 3'b111;
  localparam logic [2:0] RQ_0    = 3'b000;
  localparam logic [2:0] RQ_I    = 3'b100;
  localparam logic [2:0] RQ_R    = 3'b010;
  localparam logic [2:0] RQ_IR   = 3'b110;
  localparam logic [2:0] RQ_IW   = 3'b101;

  typedef struct packed {
    logic [10:0]   ctl;
    logic [15:0]   ifi;
    logic [15:0]   mrd;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
    logic          chk;
  } exp_t;

  logic clk = 1'b1;
  logic reset;
  logic imem_resp, mem_req, mem_we, dmem_resp, load_use, br_taken;
  logic [15:0] imem_rdata, dmem_rdata;
  logic imem_read, dmem_read, dmem_write;
  logic [15:0] if_instr, mem_rdata;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  pipe_stall_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .imem_read(imem_read), .if_instr(if_instr),
    .mem_req(mem_req), .mem_we(mem_we), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .mem_rdata(mem_rdata),
    .load_use(load_use), .br_taken(br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] c(input logic [4:0] ld, input logic [2:0] fl, input logic [2:0] rq);
    return {ld, fl, rq};
  endfunction

  // Drive one cycle of inputs, push its expectation, advance past the next posedge.
  task automatic step(input logic rst, input logic ir, input logic [15:0] ird,
                      input logic mr, input logic mw, input logic dr, input logic [15:0] drd,
                      input logic lu, input logic bt,
                      input logic [10:0] ectl, input logic [15:0] eif, input logic [15:0] emem,
                      input logic chk);
    exp_t e;
    reset = rst; imem_resp = ir; imem_rdata = ird; mem_req = mr; mem_we = mw;
    dmem_resp = dr; dmem_rdata = drd; load_use = lu; br_taken = bt;
    e.ctl = ectl; e.ifi = eif; e.mrd = emem;
    e.scnt = exp_stall; e.fcnt = exp_flush; e.chk = chk;
    sb.push_back(e);
    if (rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!ectl[6]) exp_stall = exp_stall + CW'(1);
      if (ectl[5])  exp_flush = exp_flush + CW'(1);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, imem_read, dmem_read, dmem_write};
        checks++;
        if (got !== e.ctl) begin
          failures++;
          $display("FAIL ctl cyc=%0d got=%b exp=%b", cyc, got, e.ctl);
        end
        if (e.chk) begin
          checks++;
          if (if_instr !== e.ifi) begin
            failures++;
            $display("FAIL if_instr cyc=%0d got=%h exp=%h", cyc, if_instr, e.ifi);
          end
          checks++;
          if (mem_rdata !== e.mrd) begin
            failures++;
            $display("FAIL mem_rdata cyc=%0d got=%h exp=%h", cyc, mem_rdata, e.mrd);
          end
          checks++;
          if (stall_cnt !== e.scnt) begin
            failures++;
            $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, e.scnt);
          end
          checks++;
          if (flush_cnt !== e.fcnt) begin
            failures++;
            $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", cyc, flush_cnt, e.fcnt);
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    // Reset for two cycles with imem_resp high: nothing loads or requests.
    step(1, 1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_0), 16'h1111, 16'h0000, 0);
    step(1, 1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_0), 16'h1111, 16'h0000, 1);

    // I-miss for three cycles, then advance.
    for (int i = 0; i < 3; i++)
      step(0, 0, 16'hAAAA, 0, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_I), 16'hAAAA, 16'h0000, 1);
    step(0, 1, 16'h3001, 0, 0, 0, 16'h0000, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h3001, 16'h0000, 1);

    // I first: imem returns 1234 while the load misses two more cycles.
    step(0, 1, 16'h1234, 1, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_IR), 16'h1234, 16'h0000, 1);
    step(0, 0, 16'hDEAD, 1, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_R), 16'h1234, 16'h0000, 1);
    step(0, 0, 16'hDEAD, 1, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_R), 16'h1234, 16'h0000, 1);
    step(0, 0, 16'hDEAD, 1, 0, 1, 16'h5A5A, 0, 0, c(LD_ALL, FL_NONE, RQ_R), 16'h1234, 16'h5A5A, 1);
    step(0, 1, 16'h0F0F, 0, 0, 0, 16'h0000, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h0F0F, 16'h0000, 1);

    // D first: dmem returns BEEF, imem arrives two cycles later.
    step(0, 0, 16'h0000, 1, 0, 1, 16'hBEEF, 0, 0, c(LD_NONE, FL_NONE, RQ_IR), 16'h0000, 16'hBEEF, 1);
    step(0, 0, 16'h0000, 1, 0, 0, 16'h1111, 0, 0, c(LD_NONE, FL_NONE, RQ_I), 16'h0000, 16'hBEEF, 1);
    step(0, 1, 16'h2222, 1, 0, 0, 16'h1111, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h2222, 16'hBEEF, 1);

    // Store hit on both sides.
    step(0, 1, 16'h3333, 1, 1, 1, 16'h4444, 0, 0, c(LD_ALL, FL_NONE, RQ_IW), 16'h3333, 16'h4444, 1);

    // Load-use bubble, then branch overriding load-use, then branch during a stall.
    step(0, 1, 16'h5555, 0, 0, 0, 16'h0000, 1, 0, c(LD_LU, FL_LU, RQ_I), 16'h5555, 16'h0000, 1);
    step(0, 1, 16'h6666, 0, 0, 0, 16'h0000, 1, 1, c(LD_ALL, FL_BR, RQ_I), 16'h6666, 16'h0000, 1);
    step(0, 0, 16'h6666, 0, 0, 0, 16'h0000, 0, 1, c(LD_NONE, FL_NONE, RQ_I), 16'h6666, 16'h0000, 1);
    step(0, 1, 16'h6767, 0, 0, 0, 16'h0000, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h6767, 16'h0000, 1);

    // Reset mid-miss: I_HELD visible during reset, RUN afterwards.
    step(0, 1, 16'h7777, 1, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_IR), 16'h7777, 16'h0000, 1);
    step(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_0), 16'h7777, 16'h0000, 1);
    step(0, 1, 16'h8888, 0, 0, 0, 16'h0000, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h8888, 16'h0000, 1);

    // Counter wrap: 17 stall cycles on a 4-bit counter.
    for (int i = 0; i < 17; i++)
      step(0, 0, 16'h9999, 0, 0, 0, 16'h0000, 0, 0, c(LD_NONE, FL_NONE, RQ_I), 16'h9999, 16'h0000, 1);
    step(0, 1, 16'h9A9A, 0, 0, 0, 16'h0000, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h9A9A, 16'h0000, 1);
    step(0, 1, 16'h9B9B, 0, 0, 0, 16'h0000, 0, 0, c(LD_ALL, FL_NONE, RQ_I), 16'h9B9B, 16'h0000, 1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
